alu_rr_sched: RTL and testbench
===============================

Name: alu_rr_sched

Overview:
- Shares one 8-bit combinational ALU between NUM_REQ requesters using round-robin arbitration.
- Each requester submits {a, b, op} through a valid/ready handshake.
- The ALU result is registered and returned on a single response channel, tagged with the requester ID.
- Sits between multiple day-level datapath clients and the team's existing 8-bit ALU, day4, which is instantiated unchanged.

Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..8.
- ID_W, $clog2(NUM_REQ): width of the requester ID. Derived; not overridden.

Ports:
- clk  input  1  clock; all logic is on the rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- req_valid_i  input  NUM_REQ  per-requester request valid.
- req_ready_o  output  NUM_REQ  per-requester accept; at most one bit high (one-hot or zero).
- req_a_i  input  NUM_REQ*8  operand A, packed; requester k uses bits [8k+7:8k].
- req_b_i  input  NUM_REQ*8  operand B, packed the same way.
- req_op_i  input  NUM_REQ*3  opcode, packed; requester k uses bits [3k+2:3k].
- rsp_valid_o  output  1  response valid.
- rsp_ready_i  input  1  response consumer ready.
- rsp_id_o  output  ID_W  index of the requester that owns the response.
- rsp_data_o  output  8  ALU result.
- rsp_zero_o  output  1  high when rsp_data_o == 0.

Behaviour:
- Reset (asynchronous, reset_n low):
  - rsp_valid_o=0, rsp_id_o=0, rsp_data_o=0, rsp_zero_o=0.
  - Round-robin pointer is set to 0.
  - req_ready_o=0 while reset is asserted.
- Reset asserted mid-transaction discards the held response; no request is accepted during reset.
- State: a single response slot with two states.
  - EMPTY: rsp_valid_o=0.
  - FULL: rsp_valid_o=1.
- Slot free this cycle = EMPTY, or (FULL and rsp_ready_i=1).
- Arbitration (combinational) when the slot is free:
  - Scan req_valid_i starting at the pointer, ascending with wrap-around.
  - The first set bit k is granted and req_ready_o[k]=1.
  - With no valid requests, or when the slot is not free, req_ready_o=0.
- Transfer happens on a clock edge when req_valid_i[k] and req_ready_o[k] are both high.
  - Operands of requester k are muxed into the ALU, and the result is captured into rsp_data_o.
  - rsp_id_o=k; rsp_zero_o=(result==0); state becomes FULL.
  - Pointer becomes (k+1) mod NUM_REQ.
- Latency: the response is visible in the cycle after acceptance.
- Throughput: 1 request/cycle when rsp_ready_i is held high. A same-cycle response pop and new grant go to FULL with new data.
- A response pop with no grant goes to EMPTY.
- Pointer only advances on a transfer; with no transfer it holds.
- While FULL and rsp_ready_i=0, all rsp_* outputs stay stable and req_ready_o=0.
- Requester rules:
  - A requester must hold valid, a, b and op stable until accepted.
  - req_ready_o may depend combinationally on req_valid_i, so requesters must not wait for ready before asserting valid.
- ALU semantics (8-bit, result truncated to 8 bits):
  - 000 add; 001 sub (wraps).
  - 010 a<<b[2:0]; 011 a>>b[2:0] (logical).
  - 100 and; 101 or; 110 xor.
  - 111 (a==b) gives 8'd1, otherwise 8'd0.
- No starvation: any requester holding valid is granted within NUM_REQ transfers.

Decomposition:
- Package alu_sched_pkg holds:
  - typedef alu_op_t, 3-bit enum: OP_ADD, OP_SUB, OP_SHL, OP_SHR, OP_AND, OP_OR, OP_XOR, OP_EQ.
  - typedef alu_req_t as a struct {a, b, op}.
  - constant DATA_W=8.
- Sub-module rr_arbiter is natural and reusable:
  - Inputs: req vector, pointer, enable.
  - Outputs: one-hot grant and encoded index.
- Instantiate day4 once for the shared datapath; the top level holds the response slot and pointer.

Test Plan:
- Single request, requester 0, a=200, b=100, op=000, rsp_ready_i=1 -> next cycle rsp_valid_o=1, rsp_data_o=8'd44, rsp_id_o=0, rsp_zero_o=0.
- All 4 requesters valid continuously from reset, rsp_ready_i=1 -> responses on 4 consecutive cycles with ids 0,1,2,3,0,1... Never two req_ready_o bits high at once.
- Response backpressure: req 2 (a=8'h0F, b=8'h0F, op=110) accepted, then rsp_ready_i=0 for 3 cycles:
  - rsp_data_o=8'h00, rsp_zero_o=1, held stable; req_ready_o=0 throughout.
  - On rsp_ready_i=1, the pending req 3 is granted in the same cycle.
- Shift masking: a=8'h81, b=8'd9, op=010 -> 8'h02. Same operands with op=011 -> 8'h40.
- Compare: a=5, b=5, op=111 -> 8'd1. Then a=5, b=6, op=111 -> 8'd0 with rsp_zero_o=1.
- Reset mid-operation: assert reset_n=0 while FULL with req 1 valid -> rsp_valid_o drops immediately (asynchronously). After release, the first grant goes to req 0 if it is valid (pointer back to 0).

Source files
------------

// File: rtl/alu_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_sched_pkg
// Brief    : Shared types and constants for the round-robin ALU scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package alu_sched_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_SHL = 3'b010,
        OP_SHR = 3'b011,
        OP_AND = 3'b100,
        OP_OR  = 3'b101,
        OP_XOR = 3'b110,
        OP_EQ  = 3'b111
    } alu_op_t;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
        alu_op_t           op;
    } alu_req_t;

    typedef enum logic [0:0] {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_state_t;

endpackage
`default_nettype wire

// File: rtl/day4.sv
`default_nettype none
// ============================================================================
// Module   : day4
// Brief    : Existing 8-bit combinational ALU shared by the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module day4
    import alu_sched_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [2:0]        op,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            // Only the low three bits of b are a shift amount.
            OP_SHL: result = a << b[2:0];
            OP_SHR: result = a >> b[2:0];
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_EQ:  result = {{(DATA_W-1){1'b0}}, (a == b)};
            default: result = '0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin arbiter; scans upward from ptr with wrap.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             en,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic found;
    int   pos;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        for (int i = 0; i < N; i++) begin
            pos = int'(ptr) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (en && !found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                idx      = IDX_W'(pos);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : alu_rr_sched
// Brief    : Round-robin sharing of one day4 ALU with a single registered response slot.
// Revision : 1.0 - initial release
// ============================================================================
module alu_rr_sched
    import alu_sched_pkg::*;
#(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    input  logic [NUM_REQ*8-1:0]   req_a_i,
    input  logic [NUM_REQ*8-1:0]   req_b_i,
    input  logic [NUM_REQ*3-1:0]   req_op_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [ID_W-1:0]        rsp_id_o,
    output logic [DATA_W-1:0]      rsp_data_o,
    output logic                   rsp_zero_o
);

    slot_state_t       state;
    slot_state_t       state_nxt;
    logic [ID_W-1:0]   ptr;
    logic [ID_W-1:0]   ptr_nxt;
    logic              slot_free;
    logic              arb_en;
    logic [NUM_REQ-1:0] gnt;
    logic [ID_W-1:0]   gnt_idx;
    logic              xfer;
    alu_req_t          reqs [NUM_REQ];
    alu_req_t          sel;
    logic [DATA_W-1:0] alu_y;

    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
            assign reqs[k] = {req_a_i[8*k +: 8], req_b_i[8*k +: 8], alu_op_t'(req_op_i[3*k +: 3])};
        end
    endgenerate

    // Gating with reset_n keeps ready low for the whole asynchronous reset window.
    assign slot_free = (state == SLOT_EMPTY) || rsp_ready_i;
    assign arb_en    = slot_free && reset_n;

    rr_arbiter #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_arb (
        .req (req_valid_i),
        .ptr (ptr),
        .en  (arb_en),
        .gnt (gnt),
        .idx (gnt_idx)
    );

    assign req_ready_o = gnt;
    assign xfer        = |gnt;
    assign sel         = reqs[gnt_idx];

    day4 u_alu (
        .a      (sel.a),
        .b      (sel.b),
        .op     (sel.op),
        .result (alu_y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= SLOT_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        if (xfer) begin
            state_nxt = SLOT_FULL;
            ptr_nxt   = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
        end else if (state == SLOT_FULL && rsp_ready_i) begin
            state_nxt = SLOT_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr        <= '0;
            rsp_id_o   <= '0;
            rsp_data_o <= '0;
            rsp_zero_o <= 1'b0;
        end else begin
            ptr <= ptr_nxt;
            if (xfer) begin
                rsp_id_o   <= gnt_idx;
                rsp_data_o <= alu_y;
                rsp_zero_o <= (alu_y == '0);
            end
        end
    end

    assign rsp_valid_o = (state == SLOT_FULL);

endmodule
`default_nettype wire

// File: tb/tb_alu_rr_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_rr_sched
// Brief    : Directed self-checking bench for alu_rr_sched (NUM_REQ = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_rr_sched;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NR-1:0] req_valid_i = '0;
    logic [NR-1:0] req_ready_o;
    logic [NR*8-1:0] req_a_i;
    logic [NR*8-1:0] req_b_i;
    logic [NR*3-1:0] req_op_i;
    logic          rsp_valid_o;
    logic          rsp_ready_i = 1'b0;
    logic [1:0]    rsp_id_o;
    logic [7:0]    rsp_data_o;
    logic          rsp_zero_o;

    logic [7:0] ta [NR];
    logic [7:0] tb [NR];
    logic [2:0] top [NR];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    always_comb begin
        req_a_i  = '0;
        req_b_i  = '0;
        req_op_i = '0;
        for (int k = 0; k < NR; k++) begin
            req_a_i[8*k +: 8]  = ta[k];
            req_b_i[8*k +: 8]  = tb[k];
            req_op_i[3*k +: 3] = top[k];
        end
    end

    alu_rr_sched #(.NUM_REQ(NR)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_a_i     (req_a_i),
        .req_b_i     (req_b_i),
        .req_op_i    (req_op_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_id_o    (rsp_id_o),
        .rsp_data_o  (rsp_data_o),
        .rsp_zero_o  (rsp_zero_o)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        ta[k]  = a;
        tb[k]  = b;
        top[k] = op;
    endtask

    task automatic do_reset();
        req_valid_i = '0;
        rsp_ready_i = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b0;
        cyc();
        #2 reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_reset();
        for (int k = 0; k < NR; k++) set_req(k, 8'h00, 8'h00, 3'b000);
        reset_n     = 1'b0;
        req_valid_i = 4'hF;
        rsp_ready_i = 1'b1;
        cyc();
        cyc();
        n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rsp_valid_o); end
        n_checks++; if (rsp_id_o !== 2'd0) begin n_fail++; $display("FAIL reset_id got=%0d exp=0", rsp_id_o); end
        n_checks++; if (rsp_data_o !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", rsp_data_o); end
        n_checks++; if (rsp_zero_o !== 1'b0) begin n_fail++; $display("FAIL reset_zero got=%b exp=0", rsp_zero_o); end
        n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready_o); end
        req_valid_i = '0;
        #2 reset_n = 1'b1;
        cyc();
    endtask

    task automatic test_single();
        rsp_ready_i = 1'b1;
        set_req(0, 8'd200, 8'd100, 3'b000);
        req_valid_i = 4'b0001;
        #1;
        n_checks++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL single_ready got=%b exp=0001", req_ready_o); end
        cyc();
        req_valid_i = '0;
        n_checks++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", rsp_valid_o); end
        n_checks++; if (rsp_data_o !== 8'd44) begin n_fail++; $display("FAIL single_data got=%0d exp=44", rsp_data_o); end
        n_checks++; if (rsp_id_o !== 2'd0) begin n_fail++; $display("FAIL single_id got=%0d exp=0", rsp_id_o); end
        n_checks++; if (rsp_zero_o !== 1'b0) begin n_fail++; $display("FAIL single_zero got=%b exp=0", rsp_zero_o); end
        cyc();
        n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL single_pop got=%b exp=0", rsp_valid_o); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_rdy;
        do_reset();
        // requester k computes (k+1)+1, so data identifies the owner
        for (int k = 0; k < NR; k++) set_req(k, 8'(k + 1), 8'd1, 3'b000);
        rsp_ready_i = 1'b1;
        req_valid_i = 4'hF;
        for (int i = 0; i < 8; i++) begin
            #1;
            exp_rdy = 4'b0001 << (i % 4);
            n_checks++; if ($countones(req_ready_o) > 1) begin n_fail++; $display("FAIL b2b_onehot cyc=%0d got=%b exp=onehot", i, req_ready_o); end
            n_checks++; if (req_ready_o !== exp_rdy) begin n_fail++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", i, req_ready_o, exp_rdy); end
            cyc();
            n_checks++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'(i % 4)) begin n_fail++; $display("FAIL b2b_id cyc=%0d got=%b/%0d exp=1/%0d", i, rsp_valid_o, rsp_id_o, i % 4); end
            n_checks++; if (rsp_data_o !== 8'(i % 4 + 2)) begin n_fail++; $display("FAIL b2b_data cyc=%0d got=%0d exp=%0d", i, rsp_data_o, i % 4 + 2); end
        end
        req_valid_i = '0;
        cyc();
    endtask

    task automatic test_backpressure();
        do_reset();
        rsp_ready_i = 1'b1;
        set_req(2, 8'h0F, 8'h0F, 3'b110);
        set_req(3, 8'd3, 8'd4, 3'b000);
        req_valid_i = 4'b0100;
        #1;
        n_checks++; if (req_ready_o !== 4'b0100) begin n_fail++; $display("FAIL bp_grant2 got=%b exp=0100", req_ready_o); end
        cyc();
        req_valid_i = 4'b1000;
        rsp_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL bp_ready cyc=%0d got=%b exp=0000", i, req_ready_o); end
            n_checks++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd2) begin n_fail++; $display("FAIL bp_hold cyc=%0d got=%b/%0d exp=1/2", i, rsp_valid_o, rsp_id_o); end
            n_checks++; if (rsp_data_o !== 8'h00 || rsp_zero_o !== 1'b1) begin n_fail++; $display("FAIL bp_data cyc=%0d got=%h/%b exp=00/1", i, rsp_data_o, rsp_zero_o); end
            cyc();
        end
        rsp_ready_i = 1'b1;
        #1;
        n_checks++; if (req_ready_o !== 4'b1000) begin n_fail++; $display("FAIL bp_release got=%b exp=1000", req_ready_o); end
        cyc();
        req_valid_i = '0;
        n_checks++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd3 || rsp_data_o !== 8'd7) begin n_fail++; $display("FAIL bp_next got=%b/%0d/%0d exp=1/3/7", rsp_valid_o, rsp_id_o, rsp_data_o); end
        cyc();
    endtask

    task automatic test_shift();
        rsp_ready_i = 1'b1;
        set_req(0, 8'h81, 8'd9, 3'b010);
        req_valid_i = 4'b0001;
        cyc();
        req_valid_i = '0;
        n_checks++; if (rsp_data_o !== 8'h02) begin n_fail++; $display("FAIL shl_mask got=%h exp=02", rsp_data_o); end
        set_req(0, 8'h81, 8'd9, 3'b011);
        req_valid_i = 4'b0001;
        cyc();
        req_valid_i = '0;
        n_checks++; if (rsp_data_o !== 8'h40) begin n_fail++; $display("FAIL shr_mask got=%h exp=40", rsp_data_o); end
        cyc();
    endtask

    task automatic test_compare();
        rsp_ready_i = 1'b1;
        set_req(0, 8'd5, 8'd5, 3'b111);
        req_valid_i = 4'b0001;
        cyc();
        req_valid_i = '0;
        n_checks++; if (rsp_data_o !== 8'd1 || rsp_zero_o !== 1'b0) begin n_fail++; $display("FAIL eq_true got=%0d/%b exp=1/0", rsp_data_o, rsp_zero_o); end
        set_req(0, 8'd5, 8'd6, 3'b111);
        req_valid_i = 4'b0001;
        cyc();
        req_valid_i = '0;
        n_checks++; if (rsp_data_o !== 8'd0 || rsp_zero_o !== 1'b1) begin n_fail++; $display("FAIL eq_false got=%0d/%b exp=0/1", rsp_data_o, rsp_zero_o); end
        cyc();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(0, 8'd1, 8'd1, 3'b000);
        set_req(1, 8'd9, 8'd9, 3'b100);
        rsp_ready_i = 1'b0;
        req_valid_i = 4'b0001;
        cyc();
        req_valid_i = 4'b0011;
        n_checks++; if (rsp_valid_o !== 1'b1) begin n_fail++; $display("FAIL mid_full got=%b exp=1", rsp_valid_o); end
        #2 reset_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid_o !== 1'b0) begin n_fail++; $display("FAIL mid_async got=%b exp=0", rsp_valid_o); end
        n_checks++; if (req_ready_o !== 4'b0000) begin n_fail++; $display("FAIL mid_ready got=%b exp=0000", req_ready_o); end
        cyc();
        #2 reset_n = 1'b1;
        rsp_ready_i = 1'b1;
        #1;
        // pointer was 1 before reset; after reset req 0 must win
        n_checks++; if (req_ready_o !== 4'b0001) begin n_fail++; $display("FAIL mid_ptr got=%b exp=0001", req_ready_o); end
        cyc();
        req_valid_i = '0;
        n_checks++; if (rsp_valid_o !== 1'b1 || rsp_id_o !== 2'd0 || rsp_data_o !== 8'd2) begin n_fail++; $display("FAIL mid_first got=%b/%0d/%0d exp=1/0/2", rsp_valid_o, rsp_id_o, rsp_data_o); end
        cyc();
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_shift();
        test_compare();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
